seven_segment_scanner: RTL and testbench
========================================

// Module: seven_segment_scanner
// PURPOSE
//   Time-multiplexes NUM_DIGITS BCD digits onto one shared seven_segment_converter
//   instance and a common active-low segment bus (GFEDCBA, 0 = segment lit).
//   Sequences per-digit anode enables with a programmable dwell and dead-time gap.
//   Double-buffers incoming digit data so updates apply only at frame boundaries.
//   Optional leading-zero blanking. Sits between the counter/datapath logic and board pins.
// PARAMETERS
//   NUM_DIGITS   4      number of scanned digits, 2..8
//   REFRESH_DIV  50000  clk cycles each digit is driven per visit, >= 1
//   GAP_CYCLES   2      clk cycles all anodes are off between digits, 0 = no gap
// PORTS
//   clk         in   1              system clock, rising edge
//   rst_n       in   1              asynchronous active-low reset
//   enable      in   1              1 = scan, 0 = display dark
//   lz_blank    in   1              1 = suppress leading zeros
//   load        in   1              1-cycle strobe: capture digits_in into shadow
//   digits_in   in   4*NUM_DIGITS   BCD digits, [3:0] = digit 0 (rightmost)
//   HEX         out  7              segment bus GFEDCBA, active-low
//   digit_en_n  out  NUM_DIGITS     anode enables, active-low, one-hot-low or all 1
//   load_ack    out  1              1-cycle pulse when shadow copied to display reg
// BEHAVIOUR
//   Reset (async, rst_n=0): state OFF, index 0, counters 0, display reg and shadow 0,
//     pending 0, HEX=7'h7F, digit_en_n all 1s, load_ack 0.
//   States: OFF, DRIVE, GAP. All outputs registered (1-cycle after state/index).
//     OFF:   HEX=7'h7F, anodes off. enable=1 -> DRIVE with index 0 (frame start).
//     DRIVE: anode[index] low, HEX = converter(display[index]) for REFRESH_DIV cycles,
//            then -> GAP (or directly to next DRIVE if GAP_CYCLES=0).
//     GAP:   anodes off, HEX=7'h7F for GAP_CYCLES cycles, then -> DRIVE(next index).
//   Index increments NUM_DIGITS-1 -> 0 wrap; every entry to DRIVE with index 0 is a
//     frame start.
//   enable=0 in any state: next cycle -> OFF, index and counters cleared, outputs dark.
//     shadow and pending preserved.
//   load=1: shadow <= digits_in, pending <= 1. Repeated loads overwrite shadow; one ack.
//   Frame start with pending=1: display <= shadow, pending <= 0, load_ack=1 for 1 cycle.
//   load in same cycle as frame-start apply: old shadow applied and acked; new data
//     captured, pending stays 1 for the next frame.
//   BCD values 10..15 pass to converter unchanged (shows 'E', 7'b0000110).
//   Leading-zero blank (lz_blank=1): digit k>0 blanked if display[k] and all higher
//     digits are 0; blanked digit keeps its time slot but anodes stay off and
//     HEX=7'h7F. Digit 0 never blanked (0000 shows "   0").
//   Never more than one anode low; no anode low while HEX changes digit (gap >= 0
//     guaranteed since HEX and anode update in the same registered cycle).
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4, GAP_CYCLES=1 unless stated)
//   Reset mid-DRIVE -> HEX=7'h7F, digit_en_n=4'b1111 same cycle; load_ack 0.
//   load 16'h1234, enable=1 -> ack at next frame start; anodes 1110,1111,1101,1111..
//     each low 4 cycles; HEX 0011001(4),0110000(3),0100100(2),1111001(1); period 20.
//   load 16'h0007, lz_blank=1 -> only digit 0 lit (1111000); digits 3..1 anodes off.
//   Two loads (16'h1111, 16'h2222) mid-frame -> single ack, display 2222, no tearing.
//   load 16'h00AF -> digits 1,0 show 7'b0000110; enable=0 mid-scan -> dark next cycle,
//     re-enable restarts at digit 0.
//   GAP_CYCLES=0 -> back-to-back DRIVE, anode one-hot-low every cycle, period 16.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// Seven-segment scanner: time-multiplexes NUM_DIGITS BCD digits onto one
// shared converter and an active-low GFEDCBA segment bus. Digit data is
// double-buffered and swapped in only at frame start. Optional leading-zero
// blanking is supported.

// BCD to active-low GFEDCBA segment pattern; 10..15 all render as 'E'.
module seven_segment_converter (
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   // Pure lookup, shared by every digit slot.
   always_comb begin
      case (bcd_i)
         4'd0:    seg_o = 7'b1000000;
         4'd1:    seg_o = 7'b1111001;
         4'd2:    seg_o = 7'b0100100;
         4'd3:    seg_o = 7'b0110000;
         4'd4:    seg_o = 7'b0011001;
         4'd5:    seg_o = 7'b0010010;
         4'd6:    seg_o = 7'b0000010;
         4'd7:    seg_o = 7'b1111000;
         4'd8:    seg_o = 7'b0000000;
         4'd9:    seg_o = 7'b0010000;
         default: seg_o = 7'b0000110;
      endcase
   end

endmodule

module seven_segment_scanner #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int GAP_CYCLES  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    lz_blank,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   output logic [6:0]              HEX,
   output logic [NUM_DIGITS-1:0]   digit_en_n,
   output logic                    load_ack
);

   localparam int DW      = 4 * NUM_DIGITS;
   localparam int IDX_W   = $clog2(NUM_DIGITS);
   localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] DRV_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_DRIVE = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              frame_start;

   logic [DW-1:0]     shadow_q, shadow_d;
   logic [DW-1:0]     disp_q, disp_d;
   logic              pending_q, pending_d;

   logic [6:0]        hex_q, hex_d;
   logic [NUM_DIGITS-1:0] en_q, en_d;
   logic              ack_q, ack_d;

   logic [NUM_DIGITS-1:0] blank;
   logic              all_zero;
   logic [3:0]        cur_bcd;
   logic [6:0]        cur_seg;

   // Single converter fed by whichever digit the scan index points at.
   assign cur_bcd = disp_q[{idx_q, 2'b00} +: 4];

   seven_segment_converter u_conv (
      .bcd_i (cur_bcd),
      .seg_o (cur_seg)
   );

   // Scan state, digit index and dwell/gap counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_OFF;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next scan position; flags the cycle that enters DRIVE on digit 0.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      frame_start = 1'b0;
      idx_nxt     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      if (!enable) begin
         state_d = S_OFF;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_OFF: begin
               state_d     = S_DRIVE;
               idx_d       = '0;
               cnt_d       = '0;
               frame_start = 1'b1;
            end
            S_DRIVE: begin
               if (cnt_q == DRV_LAST) begin
                  cnt_d = '0;
                  if (GAP_CYCLES > 0) begin
                     state_d = S_GAP;
                  end else begin
                     idx_d       = idx_nxt;
                     frame_start = (idx_q == IDX_LAST);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  state_d     = S_DRIVE;
                  cnt_d       = '0;
                  idx_d       = idx_nxt;
                  frame_start = (idx_q == IDX_LAST);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = S_OFF;
               idx_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // A digit is blanked when it and every digit above it are zero; digit 0 never is.
   always_comb begin
      all_zero = 1'b1;
      blank    = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         all_zero = all_zero & (disp_q[4*k +: 4] == 4'd0);
         if (k != 0) blank[k] = lz_blank & all_zero;
      end
   end

   // Shadow capture and frame-boundary swap; the swap uses the old shadow even
   // if a new load arrives in the same cycle, which then stays pending.
   always_comb begin
      shadow_d  = shadow_q;
      disp_d    = disp_q;
      pending_d = pending_q;
      if (frame_start && pending_q) begin
         disp_d    = shadow_q;
         pending_d = 1'b0;
      end
      if (load) begin
         shadow_d  = digits_in;
         pending_d = 1'b1;
      end
   end

   // Double-buffer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q  <= '0;
         disp_q    <= '0;
         pending_q <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         disp_q    <= disp_d;
         pending_q <= pending_d;
      end
   end

   // Output decode: dropping enable darkens the pins on the very next edge.
   always_comb begin
      hex_d = 7'h7F;
      en_d  = '1;
      if (enable && (state_q == S_DRIVE) && !blank[idx_q]) begin
         hex_d        = cur_seg;
         en_d[idx_q]  = 1'b0;
      end
      ack_d = frame_start & pending_q;
   end

   // Registered pins so segments and anodes always switch together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hex_q <= 7'h7F;
         en_q  <= '1;
         ack_q <= 1'b0;
      end else begin
         hex_q <= hex_d;
         en_q  <= en_d;
         ack_q <= ack_d;
      end
   end

   assign HEX        = hex_q;
   assign digit_en_n = en_q;
   assign load_ack   = ack_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: two instances (with and without dead-time
// gap) driven by the same stimulus, checked every cycle against a frame-time
// model plus hand-computed frame sequences.
module tb_seven_segment_scanner;

   localparam int ND = 4;
   localparam int RD = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        lz_blank;
   logic        load;
   logic [15:0] digits_in;
   logic [6:0]  hex0, hex1;
   logic [3:0]  en0, en1;
   logic        ack0, ack1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   seven_segment_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GAP_CYCLES(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .lz_blank(lz_blank), .load(load),
      .digits_in(digits_in), .HEX(hex0), .digit_en_n(en0), .load_ack(ack0)
   );

   seven_segment_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GAP_CYCLES(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .lz_blank(lz_blank), .load(load),
      .digits_in(digits_in), .HEX(hex1), .digit_en_n(en1), .load_ack(ack1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] v);
      case (v)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h06;
      endcase
   endfunction

   // Model: position within the frame, slot = digit dwell + gap.
   int          PER [2] = '{20, 16};
   int          SLOT[2] = '{5, 4};
   bit          m_run [2];
   int          m_t   [2];
   logic [15:0] m_disp[2];
   logic [15:0] m_shad[2];
   bit          m_pend[2];
   logic [6:0]  m_hex [2];
   logic [3:0]  m_en  [2];
   bit          m_ack [2];

   always @(posedge clk or negedge rst_n) begin : model
      int dig, ph;
      bit fs, blanked;
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            m_run[d] = 0; m_t[d] = 0; m_disp[d] = '0; m_shad[d] = '0; m_pend[d] = 0;
            m_hex[d] = 7'h7F; m_en[d] = 4'hF; m_ack[d] = 0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            dig = m_t[d] / SLOT[d];
            ph  = m_t[d] % SLOT[d];
            blanked = lz_blank && (dig > 0) && ((m_disp[d] >> (4 * dig)) == 16'd0);
            m_hex[d] = 7'h7F;
            m_en[d]  = 4'hF;
            if (enable && m_run[d] && ph < RD && !blanked) begin
               m_hex[d] = seg_of(m_disp[d][4*dig +: 4]);
               m_en[d]  = ~(4'b0001 << dig);
            end
            fs = enable && (!m_run[d] || m_t[d] == PER[d] - 1);
            m_ack[d] = fs && m_pend[d];
            if (fs && m_pend[d]) begin
               m_disp[d] = m_shad[d];
               m_pend[d] = 0;
            end
            if (load) begin
               m_shad[d] = digits_in;
               m_pend[d] = 1;
            end
            if (!enable) begin
               m_run[d] = 0; m_t[d] = 0;
            end else if (!m_run[d]) begin
               m_run[d] = 1; m_t[d] = 0;
            end else begin
               m_t[d] = (m_t[d] + 1) % PER[d];
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("dut0.HEX", hex0, m_hex[0]);
      chk("dut0.digit_en_n", en0, m_en[0]);
      chk("dut0.load_ack", ack0, m_ack[0]);
      chk("dut1.HEX", hex1, m_hex[1]);
      chk("dut1.digit_en_n", en1, m_en[1]);
      chk("dut1.load_ack", ack1, m_ack[1]);
   end

   task automatic wait_ack();
      int n = 0;
      while (ack0 !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("ack_seen", ack0, 1);
   endtask

   // k = 0 is the ack cycle; hx packs digit3..digit0 patterns, 7 bits each.
   task automatic check_frame(input logic [27:0] hx, input logic [3:0] lit, input bit both);
      for (int k = 0; k <= 20; k++) begin
         logic [6:0] eh;
         logic [3:0] ee;
         int d;
         eh = 7'h7F; ee = 4'hF;
         if (k % 5 != 0) begin
            d = (k - 1) / 5;
            if (lit[d]) begin
               eh = hx[7*d +: 7];
               ee = ~(4'b0001 << d);
            end
         end
         chk("frame0_hex", hex0, eh);
         chk("frame0_en", en0, ee);
         if (both) begin
            eh = 7'h7F; ee = 4'hF;
            if (k > 0) begin
               d  = ((k - 1) / 4) % 4;
               eh = hx[7*d +: 7];
               ee = ~(4'b0001 << d);
            end
            chk("frame1_hex", hex1, eh);
            chk("frame1_en", en1, ee);
         end
         if (k < 20) @(negedge clk);
      end
   endtask

   initial begin
      int acks;
      rst_n = 1'b0; enable = 1'b0; lz_blank = 1'b0; load = 1'b0; digits_in = '0;
      @(negedge clk);
      chk("reset_hex0", hex0, 7'h7F);
      chk("reset_en0", en0, 4'hF);
      chk("reset_ack0", ack0, 0);
      chk("reset_en1", en1, 4'hF);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1234 on both instances, frames aligned from OFF.
      digits_in = 16'h1234; load = 1'b1;
      @(negedge clk);
      load = 1'b0; enable = 1'b1;
      wait_ack();
      chk("ack1_with_ack0", ack1, 1);
      check_frame({7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 1);

      // Leading-zero blanking of 0007.
      digits_in = 16'h0007; load = 1'b1; lz_blank = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_ack();
      check_frame({7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'b0001, 0);

      // Two loads inside one frame -> one ack, last data shown.
      lz_blank = 1'b0;
      repeat (2) @(negedge clk);
      digits_in = 16'h1111; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (3) @(negedge clk);
      digits_in = 16'h2222; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_ack();
      check_frame({7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, 0);
      acks = 0;
      repeat (25) begin
         @(negedge clk);
         if (ack0) acks++;
      end
      chk("no_extra_ack", acks, 0);

      // 00AF: out-of-range BCD shows E; disable mid-scan, then restart.
      digits_in = 16'h00AF; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_ack();
      check_frame({7'h40, 7'h40, 7'h06, 7'h06}, 4'hF, 0);
      repeat (7) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      chk("disable_hex0", hex0, 7'h7F);
      chk("disable_en0", en0, 4'hF);
      chk("disable_en1", en1, 4'hF);
      repeat (3) @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      chk("restart_dark_en0", en0, 4'hF);
      @(negedge clk);
      chk("restart_en0", en0, 4'hE);
      chk("restart_hex0", hex0, 7'h06);
      chk("restart_en1", en1, 4'hE);
      chk("restart_hex1", hex1, 7'h06);

      // Asynchronous reset while a digit is driven.
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_hex0", hex0, 7'h7F);
      chk("async_rst_en0", en0, 4'hF);
      chk("async_rst_ack0", ack0, 0);
      chk("async_rst_en1", en1, 4'hF);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic checked by the model.
      repeat (3000) begin
         @(negedge clk);
         load = ($urandom_range(0, 99) < 6);
         for (int i = 0; i < 4; i++)
            digits_in[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         if (enable) begin
            if ($urandom_range(0, 99) == 0) enable = 1'b0;
         end else begin
            if ($urandom_range(0, 4) == 0) enable = 1'b1;
         end
         if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;
      end
      load = 1'b0;
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
